// File: rtl/avgiq_addr_ctrl.sv
// IQ averaging sequencer: ping-pong accumulator addressing, bank swap on completion, PPC status word.
// Optional build macro AVGIQ_SYNC_CHECK_EN enables in-frame sync-error detection and re-arm.
module avgiq_addr_ctrl #(
    parameter int ADDR_W = 9,
    parameter int NAVG_W = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              enable,
    input  logic              oneshot,
    input  logic [NAVG_W-1:0] num_avg,
    input  logic              in_valid,
    input  logic              in_sync,
    input  logic              rd_ack,
    output logic              acc_we,
    output logic [ADDR_W:0]   acc_addr,
    output logic              acc_clr,
    output logic              avg_done,
    output logic [31:0]       user_data_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_ACCUM = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [NAVG_W-1:0] NAVG_ZERO = {NAVG_W{1'b0}};
    localparam logic [NAVG_W-1:0] NAVG_ONE  = {{(NAVG_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CHAN_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CHAN_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CHAN_LAST = {ADDR_W{1'b1}};

    state_t            state_r;
    logic [ADDR_W-1:0] chan_r;
    logic [NAVG_W-1:0] frame_r;
    logic [NAVG_W-1:0] navg_r;
    logic              wbank_r;
    logic              bank_r;
    logic              pending_r;
    logic              overrun_r;
    logic              sync_err_r;
    logic [12:0]       seq_r;
    logic              acc_we_r;
    logic [ADDR_W:0]   acc_addr_r;
    logic              acc_clr_r;
    logic              avg_done_r;

    logic              sync_hit_s;
    logic              resync_s;
    logic              chan_last_s;
    logic              frame_last_s;
    logic              frame_first_s;
    logic [NAVG_W-1:0] navg_eff_s;

    assign sync_hit_s    = in_valid & in_sync;
    assign chan_last_s   = (chan_r == CHAN_LAST);
    assign frame_last_s  = (frame_r == (navg_r - NAVG_ONE));
    assign frame_first_s = (frame_r == NAVG_ZERO);
    assign navg_eff_s    = (num_avg == NAVG_ZERO) ? NAVG_ONE : num_avg;

`ifdef AVGIQ_SYNC_CHECK_EN
    // A sync marker anywhere but channel 0 means the frame alignment was lost.
    assign resync_s = sync_hit_s & (chan_r != CHAN_ZERO);
`else
    assign resync_s = 1'b0;
`endif

    // Sequencer FSM with all counters, bank control and registered outputs.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_r    <= ST_IDLE;
            chan_r     <= CHAN_ZERO;
            frame_r    <= NAVG_ZERO;
            navg_r     <= NAVG_ZERO;
            wbank_r    <= 1'b0;
            bank_r     <= 1'b0;
            pending_r  <= 1'b0;
            overrun_r  <= 1'b0;
            sync_err_r <= 1'b0;
            seq_r      <= 13'd0;
            acc_we_r   <= 1'b0;
            acc_addr_r <= {(ADDR_W+1){1'b0}};
            acc_clr_r  <= 1'b0;
            avg_done_r <= 1'b0;
        end else begin
            acc_we_r   <= 1'b0;
            acc_clr_r  <= 1'b0;
            avg_done_r <= 1'b0;
            if (rd_ack) begin
                pending_r <= 1'b0;
            end

            if (!enable) begin
                state_r <= ST_IDLE;
                chan_r  <= CHAN_ZERO;
                frame_r <= NAVG_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r    <= ST_ARM;
                        chan_r     <= CHAN_ZERO;
                        frame_r    <= NAVG_ZERO;
                        overrun_r  <= 1'b0;
                        sync_err_r <= 1'b0;
                        seq_r      <= 13'd0;
                        pending_r  <= 1'b0;
                    end
                    ST_ARM: begin
                        if (sync_hit_s) begin
                            state_r    <= ST_ACCUM;
                            navg_r     <= navg_eff_s;
                            acc_we_r   <= 1'b1;
                            acc_clr_r  <= 1'b1;
                            acc_addr_r <= {wbank_r, CHAN_ZERO};
                            chan_r     <= CHAN_ONE;
                            frame_r    <= NAVG_ZERO;
                        end
                    end
                    ST_ACCUM: begin
                        if (in_valid && resync_s) begin
                            // Discard the partial average; this sample restarts it as channel 0.
                            sync_err_r <= 1'b1;
                            navg_r     <= navg_eff_s;
                            acc_we_r   <= 1'b1;
                            acc_clr_r  <= 1'b1;
                            acc_addr_r <= {wbank_r, CHAN_ZERO};
                            chan_r     <= CHAN_ONE;
                            frame_r    <= NAVG_ZERO;
                        end else if (in_valid) begin
                            acc_we_r   <= 1'b1;
                            acc_clr_r  <= frame_first_s;
                            acc_addr_r <= {wbank_r, chan_r};
                            if (chan_last_s) begin
                                chan_r <= CHAN_ZERO;
                                if (frame_last_s) begin
                                    frame_r    <= NAVG_ZERO;
                                    bank_r     <= wbank_r;
                                    wbank_r    <= ~wbank_r;
                                    seq_r      <= seq_r + 13'd1;
                                    avg_done_r <= 1'b1;
                                    // A same-cycle ack consumes the old bank, so no overrun.
                                    pending_r  <= 1'b1;
                                    if (pending_r && !rd_ack) begin
                                        overrun_r <= 1'b1;
                                    end
                                    if (oneshot) begin
                                        state_r <= ST_WAIT;
                                    end
                                end else begin
                                    frame_r <= frame_r + NAVG_ONE;
                                end
                            end else begin
                                chan_r <= chan_r + CHAN_ONE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (rd_ack) begin
                            state_r <= ST_ARM;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign acc_we       = acc_we_r;
    assign acc_addr     = acc_addr_r;
    assign acc_clr      = acc_clr_r;
    assign avg_done     = avg_done_r;
    assign user_data_in = {bank_r, overrun_r, sync_err_r, seq_r, 16'(navg_r)};

endmodule

// File: tb/tb_avgiq_addr_ctrl.sv
// Directed self-checking bench for avgiq_addr_ctrl with ADDR_W=3 (8-channel frames).
module tb_avgiq_addr_ctrl;

    localparam int ADDR_W = 3;
    localparam int NAVG_W = 16;

    logic              user_clk = 1'b0;
    logic              user_rst_n;
    logic              enable;
    logic              oneshot;
    logic [NAVG_W-1:0] num_avg;
    logic              in_valid;
    logic              in_sync;
    logic              rd_ack;
    logic              acc_we;
    logic [ADDR_W:0]   acc_addr;
    logic              acc_clr;
    logic              avg_done;
    logic [31:0]       user_data_in;

    int checks = 0;
    int errors = 0;
    logic we_seen;

    avgiq_addr_ctrl #(.ADDR_W(ADDR_W), .NAVG_W(NAVG_W)) dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .enable       (enable),
        .oneshot      (oneshot),
        .num_avg      (num_avg),
        .in_valid     (in_valid),
        .in_sync      (in_sync),
        .rd_ack       (rd_ack),
        .acc_we       (acc_we),
        .acc_addr     (acc_addr),
        .acc_clr      (acc_clr),
        .avg_done     (avg_done),
        .user_data_in (user_data_in)
    );

    always #5 user_clk = ~user_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        @(negedge user_clk);
    endtask

    // n back-to-back samples; checks {avg_done, acc_we, acc_clr, acc_addr} for each.
    task automatic feed(input string tag, input int n, input logic [3:0] base,
                        input logic clr, input logic sync0, input logic done_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sync  = sync0 && (i == 0);
            step();
            check_eq(tag, {25'd0, avg_done, acc_we, acc_clr, acc_addr},
                     {25'd0, done_last && (i == n - 1), 1'b1, clr, base + 4'(i)});
        end
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic ack_pulse();
        in_valid = 1'b0;
        rd_ack   = 1'b1;
        step();
        rd_ack   = 1'b0;
    endtask

    // Drive input for n cycles and report whether any write appeared.
    task automatic idle_input(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sync  = ((i % 8) == 0);
            step();
            seen = seen | acc_we;
        end
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    initial begin
        user_rst_n = 1'b0;
        enable     = 1'b0;
        oneshot    = 1'b0;
        num_avg    = 16'd0;
        in_valid   = 1'b0;
        in_sync    = 1'b0;
        rd_ack     = 1'b0;
        repeat (2) @(negedge user_clk);
        check_eq("rst_outs", {28'd0, avg_done, acc_we, acc_clr, 1'b0}, 32'd0);
        check_eq("rst_addr", {28'd0, acc_addr}, 32'd0);
        check_eq("rst_status", user_data_in, 32'h0000_0000);
        user_rst_n = 1'b1;
        step();

        // Continuous averaging, num_avg=2, no acknowledge across two completions.
        enable  = 1'b1;
        num_avg = 16'd2;
        step();
        feed("t1_f0", 8, 4'd0, 1'b1, 1'b1, 1'b0);
        feed("t1_f1", 8, 4'd0, 1'b0, 1'b1, 1'b1);
        check_eq("t1_status", user_data_in, 32'h0001_0002);
        feed("t1_g0", 8, 4'd8, 1'b1, 1'b1, 1'b0);
        feed("t1_g1", 8, 4'd8, 1'b0, 1'b1, 1'b1);
        check_eq("t1_overrun", user_data_in, 32'hC002_0002);
        ack_pulse();

        // Disable holds the status word; re-enable clears stickies and sequence.
        enable = 1'b0;
        step();
        check_eq("dis_hold", user_data_in, 32'hC002_0002);
        check_eq("dis_we", {31'd0, acc_we}, 32'd0);
        enable  = 1'b1;
        oneshot = 1'b1;
        num_avg = 16'd1;
        step();
        check_eq("reen_status", user_data_in, 32'h8000_0002);

        // One-shot: stop after one average until acknowledged.
        feed("os_a", 8, 4'd0, 1'b1, 1'b1, 1'b1);
        check_eq("os_a_status", user_data_in, 32'h0001_0001);
        idle_input(20, we_seen);
        check_eq("os_wait_no_we", {31'd0, we_seen}, 32'd0);
        ack_pulse();
        feed("os_b", 8, 4'd8, 1'b1, 1'b1, 1'b1);
        check_eq("os_b_status", user_data_in, 32'h8002_0001);

        // Sync injected at chan 5 of frame 1.
        oneshot = 1'b0;
        num_avg = 16'd2;
        ack_pulse();
        feed("s_f0", 8, 4'd0, 1'b1, 1'b1, 1'b0);
        feed("s_f1", 5, 4'd0, 1'b0, 1'b1, 1'b0);
`ifdef AVGIQ_SYNC_CHECK_EN
        feed("s_inj", 1, 4'd0, 1'b1, 1'b1, 1'b0);
        check_eq("s_inj_status", user_data_in, 32'hA002_0002);
        feed("s_rec0", 7, 4'd1, 1'b1, 1'b0, 1'b0);
        feed("s_rec1", 8, 4'd0, 1'b0, 1'b1, 1'b1);
        check_eq("s_done_status", user_data_in, 32'h2003_0002);
`else
        feed("s_inj", 1, 4'd5, 1'b0, 1'b1, 1'b0);
        check_eq("s_inj_status", user_data_in, 32'h8002_0002);
        feed("s_tail", 2, 4'd6, 1'b0, 1'b0, 1'b1);
        check_eq("s_done_status", user_data_in, 32'h0003_0002);
`endif
        ack_pulse();

        // num_avg=0 behaves as 1: every frame completes.
        enable = 1'b0;
        step();
        enable  = 1'b1;
        num_avg = 16'd0;
        step();
        check_eq("n0_arm_status", user_data_in, 32'h0000_0002);
        feed("n0_a", 8, 4'd8, 1'b1, 1'b1, 1'b1);
        check_eq("n0_a_status", user_data_in, 32'h8001_0001);
        feed("n0_b", 7, 4'd0, 1'b1, 1'b1, 1'b0);
        rd_ack = 1'b1;
        feed("n0_b_last", 1, 4'd7, 1'b1, 1'b0, 1'b1);
        rd_ack = 1'b0;
        check_eq("n0_b_ack_same", user_data_in, 32'h0002_0001);
        feed("n0_c", 8, 4'd8, 1'b1, 1'b1, 1'b1);
        check_eq("n0_c_overrun", user_data_in, 32'hC003_0001);

        // Abort mid-frame, restart waits for sync, wbank retained.
        feed("ab_part", 3, 4'd0, 1'b1, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        check_eq("ab_hold", user_data_in, 32'hC003_0001);
        enable = 1'b1;
        step();
        check_eq("ab_clear", user_data_in, 32'h8000_0001);
        in_valid = 1'b1;
        in_sync  = 1'b0;
        we_seen  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            we_seen = we_seen | acc_we;
        end
        in_valid = 1'b0;
        check_eq("ab_wait_sync", {31'd0, we_seen}, 32'd0);
        feed("ab_resync", 1, 4'd0, 1'b1, 1'b1, 1'b0);
        feed("ab_post", 2, 4'd1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-average.
        in_valid = 1'b1;
        #2;
        user_rst_n = 1'b0;
        #1;
        check_eq("arst_outs", {27'd0, avg_done, acc_we, acc_clr, acc_addr[0], acc_addr[3]}, 32'd0);
        check_eq("arst_status", user_data_in, 32'h0000_0000);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
